// File: rtl/tcm_ifetch_port_if.sv
// Fetch-side and RAM-side signal bundle for the TCM instruction fetch port.
// The slave modport is the fetch port itself; master is the core plus RAM array.
interface tcm_ifetch_port_if #(
  parameter int unsigned TCM_SIZE_LOG2 = 17
) ();

  // Core fetch interface
  logic        mem_i_rd_i;
  logic        mem_i_flush_i;
  logic        mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o;
  logic        mem_i_valid_o;
  logic        mem_i_error_o;
  logic [63:0] mem_i_inst_o;

  // TCM RAM array interface
  logic                       ram_rd_o;
  logic [TCM_SIZE_LOG2-4:0]   ram_addr_o;
  logic [63:0]                ram_data_i;
  logic                       ram_busy_i;

  modport master (
    output mem_i_rd_i,
    output mem_i_flush_i,
    output mem_i_invalidate_i,
    output mem_i_pc_i,
    input  mem_i_accept_o,
    input  mem_i_valid_o,
    input  mem_i_error_o,
    input  mem_i_inst_o,
    input  ram_rd_o,
    input  ram_addr_o,
    output ram_data_i,
    output ram_busy_i
  );

  modport slave (
    input  mem_i_rd_i,
    input  mem_i_flush_i,
    input  mem_i_invalidate_i,
    input  mem_i_pc_i,
    output mem_i_accept_o,
    output mem_i_valid_o,
    output mem_i_error_o,
    output mem_i_inst_o,
    output ram_rd_o,
    output ram_addr_o,
    input  ram_data_i,
    input  ram_busy_i
  );

endinterface

// File: rtl/tcm_ifetch_port.sv
// TCM instruction-fetch front end: range-checks fetch PCs, issues single-cycle RAM
// reads and returns 64-bit instruction pairs one cycle later.
module tcm_ifetch_port #(
  parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
  parameter int unsigned TCM_SIZE_LOG2 = 17,
  parameter int unsigned INV_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  tcm_ifetch_port_if.slave         bus,
  output logic [31:0]              fetch_count_o
);

  localparam int unsigned AW = TCM_SIZE_LOG2 - 3;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StInval = 1'b1;

  localparam logic [3:0] InvReload = 4'(INV_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  inv_cnt_q, inv_cnt_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic        take;
  logic        in_range;
  logic [31:0] pc_off;
  logic        valid;
  logic        unused_off;

  // Accept is gated by rst so nothing leaks out while held in reset.
  assign accept = (state_q == StRun) && !bus.ram_busy_i && !bus.mem_i_flush_i &&
                  !bus.mem_i_invalidate_i && rst;
  assign take   = bus.mem_i_rd_i && accept;

  assign pc_off     = bus.mem_i_pc_i - ADDR_BASE;
  assign in_range   = (pc_off[31:TCM_SIZE_LOG2] == '0) && (bus.mem_i_pc_i[2:0] == 3'b000);
  assign unused_off = ^pc_off[2:0];

  assign valid = pend_q && !bus.mem_i_flush_i && rst;

  assign bus.mem_i_accept_o = accept;
  assign bus.mem_i_valid_o  = valid;
  assign bus.mem_i_error_o  = valid && err_q;
  assign bus.mem_i_inst_o   = (valid && !err_q) ? bus.ram_data_i : 64'h0;
  assign bus.ram_rd_o       = take && in_range;
  assign bus.ram_addr_o     = (take && in_range) ? pc_off[TCM_SIZE_LOG2-1:3] : {AW{1'b0}};

  assign fetch_count_o = count_q;

  // Invalidate stall: INV_CYCLES cycles in StInval after the request cycle.
  always_comb begin
    state_d   = state_q;
    inv_cnt_d = inv_cnt_q;
    unique case (state_q)
      StRun: begin
        if (bus.mem_i_invalidate_i) begin
          state_d   = StInval;
          inv_cnt_d = InvReload;
        end
      end
      StInval: begin
        if (bus.mem_i_invalidate_i) begin
          inv_cnt_d = InvReload;
        end else if (inv_cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          inv_cnt_d = inv_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = StRun;
        inv_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    pend_d  = take;
    err_d   = take && !in_range;
    count_d = count_q;
    if (valid && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRun;
      inv_cnt_q <= 4'd0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      inv_cnt_q <= inv_cnt_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  ram_rd_implies_accept: assert property (@(posedge clk) bus.ram_rd_o |-> bus.mem_i_accept_o);
  error_implies_valid:   assert property (@(posedge clk) bus.mem_i_error_o |-> bus.mem_i_valid_o);
  no_accept_in_inval:    assert property (@(posedge clk)
                                          (state_q == StInval) |-> !bus.mem_i_accept_o);

endmodule

// File: tb/tb_tcm_ifetch_port.sv
// Directed bench for tcm_ifetch_port with a registered-read RAM model.
module tb_tcm_ifetch_port;

  localparam int unsigned SizeLog2 = 17;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_count;
  logic [63:0] ram_q;
  logic [63:0] mem [0:7];

  int n_checks;
  int n_errors;

  tcm_ifetch_port_if #(.TCM_SIZE_LOG2(SizeLog2)) bus ();

  tcm_ifetch_port #(
    .ADDR_BASE    (32'h8000_0000),
    .TCM_SIZE_LOG2(SizeLog2),
    .INV_CYCLES   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .fetch_count_o(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM array: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.ram_rd_o) ram_q <= mem[bus.ram_addr_o[2:0]];
  end
  assign bus.ram_data_i = ram_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ram_q    = 64'h0;
    mem[0] = 64'h00B5_0633_0090_0593;
    mem[1] = 64'h1111_1111_2222_2222;
    mem[2] = 64'h3333_3333_4444_4444;
    mem[3] = 64'h5555_5555_6666_6666;
    for (int i = 4; i < 8; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

    rst                    = 1'b0;
    bus.mem_i_rd_i         = 1'b1;
    bus.mem_i_flush_i      = 1'b0;
    bus.mem_i_invalidate_i = 1'b0;
    bus.mem_i_pc_i         = 32'h8000_0000;
    bus.ram_busy_i         = 1'b0;

    // Reset state, with a request held so the rst gating is exercised
    next_cycle(); next_cycle(); #1;
    check("rst_accept", 64'(bus.mem_i_accept_o), 64'd0);
    check("rst_valid",  64'(bus.mem_i_valid_o), 64'd0);
    check("rst_ram_rd", 64'(bus.ram_rd_o), 64'd0);
    check("rst_addr",   64'(bus.ram_addr_o), 64'd0);
    check("rst_inst",   bus.mem_i_inst_o, 64'd0);
    check("rst_count",  64'(fetch_count), 64'd0);

    // Basic fetch
    next_cycle(); rst = 1'b1; #1;
    check("basic_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("basic_ram_rd", 64'(bus.ram_rd_o), 64'd1);
    check("basic_addr",   64'(bus.ram_addr_o), 64'd0);
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("basic_valid", 64'(bus.mem_i_valid_o), 64'd1);
    check("basic_error", 64'(bus.mem_i_error_o), 64'd0);
    check("basic_inst",  bus.mem_i_inst_o, 64'h00B5_0633_0090_0593);
    next_cycle(); #1;
    check("basic_count", 64'(fetch_count), 64'd1);

    // Streaming: four back-to-back takes
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.mem_i_rd_i = 1'b1;
      bus.mem_i_pc_i = 32'h8000_0000 + 32'(8 * i);
      #1;
      check("stream_accept", 64'(bus.mem_i_accept_o), 64'd1);
      check("stream_addr",   64'(bus.ram_addr_o), 64'(i));
      if (i > 0) begin
        check("stream_valid", 64'(bus.mem_i_valid_o), 64'd1);
        check("stream_inst",  bus.mem_i_inst_o, mem[i-1]);
      end
    end
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("stream_valid_last", 64'(bus.mem_i_valid_o), 64'd1);
    check("stream_inst_last",  bus.mem_i_inst_o, 64'h5555_5555_6666_6666);
    next_cycle(); #1;
    check("stream_count", 64'(fetch_count), 64'd5);
    check("stream_idle",  64'(bus.mem_i_valid_o), 64'd0);

    // Faults: out of range, then misaligned
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8002_0000; #1;
    check("oor_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("oor_ram_rd", 64'(bus.ram_rd_o), 64'd0);
    next_cycle(); bus.mem_i_pc_i = 32'h8000_0004; #1;
    check("oor_valid",  64'(bus.mem_i_valid_o), 64'd1);
    check("oor_error",  64'(bus.mem_i_error_o), 64'd1);
    check("oor_inst",   bus.mem_i_inst_o, 64'd0);
    check("mis_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("mis_ram_rd", 64'(bus.ram_rd_o), 64'd0);
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("mis_valid", 64'(bus.mem_i_valid_o), 64'd1);
    check("mis_error", 64'(bus.mem_i_error_o), 64'd1);
    check("mis_inst",  bus.mem_i_inst_o, 64'd0);
    next_cycle(); #1;
    check("fault_count", 64'(fetch_count), 64'd7);

    // Flush in the response cycle drops it
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8000_0008; #1;
    check("flush_take_addr", 64'(bus.ram_addr_o), 64'd1);
    next_cycle(); bus.mem_i_pc_i = 32'h8000_0010; bus.mem_i_flush_i = 1'b1; #1;
    check("flush_valid",  64'(bus.mem_i_valid_o), 64'd0);
    check("flush_accept", 64'(bus.mem_i_accept_o), 64'd0);
    check("flush_ram_rd", 64'(bus.ram_rd_o), 64'd0);
    next_cycle(); bus.mem_i_flush_i = 1'b0; #1;
    check("post_flush_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("post_flush_addr",   64'(bus.ram_addr_o), 64'd2);
    check("post_flush_nvalid", 64'(bus.mem_i_valid_o), 64'd0);
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("post_flush_inst", bus.mem_i_inst_o, 64'h3333_3333_4444_4444);
    next_cycle(); #1;
    check("flush_count", 64'(fetch_count), 64'd8);

    // Invalidate: accept low for exactly three cycles
    bus.mem_i_invalidate_i = 1'b1; bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8000_0018; #1;
    check("inval_k0", 64'(bus.mem_i_accept_o), 64'd0);
    next_cycle(); bus.mem_i_invalidate_i = 1'b0; #1;
    check("inval_k1", 64'(bus.mem_i_accept_o), 64'd0);
    next_cycle(); #1;
    check("inval_k2", 64'(bus.mem_i_accept_o), 64'd0);
    next_cycle(); #1;
    check("inval_k3_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("inval_k3_addr",   64'(bus.ram_addr_o), 64'd3);
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("inval_inst", bus.mem_i_inst_o, 64'h5555_5555_6666_6666);
    next_cycle(); #1;
    check("inval_count", 64'(fetch_count), 64'd9);

    // Busy: five stalled cycles with the request held
    bus.ram_busy_i = 1'b1; bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("busy_accept", 64'(bus.mem_i_accept_o), 64'd0);
      check("busy_ram_rd", 64'(bus.ram_rd_o), 64'd0);
      check("busy_valid",  64'(bus.mem_i_valid_o), 64'd0);
      next_cycle();
    end
    bus.ram_busy_i = 1'b0; #1;
    check("busy_free_accept", 64'(bus.mem_i_accept_o), 64'd1);
    check("busy_free_ram_rd", 64'(bus.ram_rd_o), 64'd1);
    next_cycle(); bus.mem_i_rd_i = 1'b0; #1;
    check("busy_inst", bus.mem_i_inst_o, 64'h00B5_0633_0090_0593);
    next_cycle(); #1;
    check("busy_count", 64'(fetch_count), 64'd10);

    // Invalidate does not cancel a pending response
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8000_0008; #1;
    check("invpend_accept", 64'(bus.mem_i_accept_o), 64'd1);
    next_cycle(); bus.mem_i_rd_i = 1'b0; bus.mem_i_invalidate_i = 1'b1; #1;
    check("invpend_valid", 64'(bus.mem_i_valid_o), 64'd1);
    check("invpend_inst",  bus.mem_i_inst_o, 64'h1111_1111_2222_2222);
    next_cycle(); bus.mem_i_invalidate_i = 1'b0; #1;
    check("invpend_count", 64'(fetch_count), 64'd11);
    next_cycle(); next_cycle();

    // Reset mid-fetch
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h8000_0010; #1;
    check("rstmid_accept", 64'(bus.mem_i_accept_o), 64'd1);
    next_cycle(); bus.mem_i_rd_i = 1'b0; rst = 1'b0; #1;
    check("rstmid_valid",  64'(bus.mem_i_valid_o), 64'd0);
    check("rstmid_error",  64'(bus.mem_i_error_o), 64'd0);
    check("rstmid_inst",   bus.mem_i_inst_o, 64'd0);
    check("rstmid_ram_rd", 64'(bus.ram_rd_o), 64'd0);
    next_cycle(); #1;
    check("rstmid_count", 64'(fetch_count), 64'd0);
    next_cycle(); rst = 1'b1; #1;
    check("rel_valid0", 64'(bus.mem_i_valid_o), 64'd0);
    next_cycle(); #1;
    check("rel_valid1", 64'(bus.mem_i_valid_o), 64'd0);
    check("rel_count",  64'(fetch_count), 64'd0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tcm_ifetch_port.md
# tcm_ifetch_port

Instruction-fetch front end of the tightly-coupled memory, sitting between the core's `mem_i_*` fetch interface and the 64-bit-wide TCM RAM array. It accepts fetch requests and decodes and range-checks the PC. It issues single-cycle RAM reads and returns 64-bit instruction pairs one cycle later. It also handles flush cancellation, invalidate stalls, data-port priority stalls and a delivered-fetch counter.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h80000000: TCM base address.
- `TCM_SIZE_LOG2`, default 17: TCM size in bytes as log2 (128 KB).
- `INV_CYCLES`, default 2: stall length after an invalidate, range 1..15.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-low.
- `mem_i_rd_i`, input, 1: fetch request.
- `mem_i_flush_i`, input, 1: cancel in-flight fetch.
- `mem_i_invalidate_i`, input, 1: invalidate request; starts the stall.
- `mem_i_pc_i`, input, 32: fetch address.
- `mem_i_accept_o`, output, 1: request accepted this cycle.
- `mem_i_valid_o`, output, 1: response valid.
- `mem_i_error_o`, output, 1: response is a fetch fault.
- `mem_i_inst_o`, output, 64: instruction pair; bits [31:0] are at the lower address.
- `ram_rd_o`, output, 1: RAM read strobe.
- `ram_addr_o`, output, TCM_SIZE_LOG2-3: 64-bit word index.
- `ram_data_i`, input, 64: RAM read data, valid the cycle after `ram_rd_o`.
- `ram_busy_i`, input, 1: data port owns the RAM this cycle; fetch must stall.
- `fetch_count_o`, output, 32: count of delivered valid responses.

## Operation
- FSM states:
  - RUN → INVAL when `mem_i_invalidate_i`=1.
  - INVAL counts `INV_CYCLES` cycles, then returns to RUN.
  - An invalidate received while in INVAL reloads the count.
- `mem_i_accept_o` = state==RUN && !`ram_busy_i` && !`mem_i_flush_i` && !`mem_i_invalidate_i` && `rst`.
- Request taken = `mem_i_rd_i` && `mem_i_accept_o`.
- Range check on a taken request:
  - In range: `mem_i_pc_i` - ADDR_BASE < 2^TCM_SIZE_LOG2 (unsigned 32-bit subtract) and `mem_i_pc_i`[2:0]==0.
  - In range → `ram_rd_o`=1 and `ram_addr_o`=(pc-ADDR_BASE)[TCM_SIZE_LOG2-1:3]; both combinational in the same cycle.
  - Out of range or misaligned → no RAM read; set `err_q`.
- `pend_q` is set on a taken request and cleared otherwise. At most one response is outstanding.
- Response cycle (cycle after the take):
  - `mem_i_valid_o` = `pend_q` && !`mem_i_flush_i`.
  - `mem_i_error_o` = `mem_i_valid_o` && `err_q`.
  - `mem_i_inst_o` = (`mem_i_valid_o` && !`err_q`) ? `ram_data_i` : 0.
- Flush masks the response presented in the same cycle; that fetch is lost and not counted.
- Back-to-back: a new request may be taken in the same cycle a response is presented, giving 1 fetch/cycle throughput.
- `fetch_count_o` increments on each `mem_i_valid_o`=1, including error responses, and saturates at 32'hFFFFFFFF.
- An invalidate does not cancel a pending response; it is still delivered.
- `ram_rd_o`=0 whenever no request is taken.

## Timing
- Reset values while `rst`=0:
  - state RUN, `pend_q`=0, `err_q`=0, count=0.
  - All outputs 0: accept, valid, error, inst, `ram_rd_o`, `ram_addr_o`.
- Latency: request taken at edge N, response presented in cycle N (the cycle after edge N) through edge N+1.
- `ram_busy_i`=1 holds accept low. The core holds `mem_i_rd_i`/`mem_i_pc_i` until accepted.
- Invalidate at cycle K: accept=0 in cycles K through K+INV_CYCLES, and accept may return at K+INV_CYCLES+1.
- Reset asserted mid-fetch: pending response discarded, no valid emitted after reset release until a new take.
- Simultaneous events in one cycle:
  - flush + valid response: response dropped.
  - flush + rd: not accepted.
  - busy + invalidate: enter INVAL.

## Test plan
- Basic fetch: RAM word 0 = 64'h00B50633_00900593; rd with pc=80000000 → accept same cycle, `ram_addr_o`=0, next cycle valid=1, error=0, inst=64'h00B50633_00900593, `fetch_count_o`=1.
- Streaming: 4 back-to-back takes at 80000000/08/10/18 → valid on 4 consecutive cycles with words 0–3, and `ram_addr_o` 0,1,2,3.
- Fault: pc=80020000 and then pc=80000004 → each accepted, no `ram_rd_o`; next cycle valid=1, error=1, inst=0; count increments by 2.
- Flush: take at 80000008, flush=1 in the response cycle → valid=0, count unchanged, accept=0 that cycle; next request at 80000010 returns word 2.
- Invalidate/busy: invalidate pulse with INV_CYCLES=2 → accept low for exactly 3 cycles. `ram_busy_i` high for 5 cycles with rd held → no take and no `ram_rd_o`, then take on the first free cycle.
- Reset mid-fetch: take, then drive `rst`=0 in the response cycle → all outputs 0, count 0; after release no spurious valid.
